// File: rtl/mine_board_cover_pkg.sv
// Shared definitions for the minesweeper cover-state board.
// Holds the 2-bit cover encoding and the default grid dimensions used by
// mine_board_cover and its per-cell sub-module.
package mine_board_cover_pkg;

  // Cover encoding. 2'b11 is never stored.
  localparam logic [1:0] COVER_HIDDEN = 2'b00;
  localparam logic [1:0] COVER_OPEN   = 2'b01;
  localparam logic [1:0] COVER_FLAG   = 2'b10;

  // Default grid geometry.
  localparam int DEFAULT_X_SIZE       = 16;
  localparam int DEFAULT_Y_SIZE       = 16;
  localparam int DEFAULT_X_COORD_BITS = 4;
  localparam int DEFAULT_Y_COORD_BITS = 4;

endpackage

// File: rtl/mine_board_cover_cell.sv
// One cell of the cover board: a 2-bit cover-state register.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears to covered)
//   sel        : the command cursor points at this cell
//   flag       : qualified flag command (already excludes flag&open)
//   open       : qualified open command (already excludes flag&open)
//   state      : stored cover state
//   opened     : combinational strobe, high when this edge will open the cell
module mine_board_cover_cell
  import mine_board_cover_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       flag,
  input  logic       open,
  output logic [1:0] state,
  output logic       opened
);

  logic [1:0] state_next;

  // Only a covered cell can be opened; opening is therefore a one-shot event.
  assign opened = sel && open && (state == COVER_HIDDEN);

  always_comb begin
    state_next = state;
    if (opened) begin
      state_next = COVER_OPEN;
    end else if (sel && flag) begin
      case (state)
        COVER_HIDDEN: state_next = COVER_FLAG;
        COVER_FLAG:   state_next = COVER_HIDDEN;
        default:      state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COVER_HIDDEN;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/mine_board_cover.sv
// Cover-state board for minesweeper: per-cell covered/opened/flagged state.
// Flag/open commands act on the cursor cell (x_pos, y_pos) each clock; the
// display scan reads the cover state at (x_coord, y_coord) combinationally.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (all covered)
//   flag, open       : level-sampled commands; both high means no action
//   x_coord, y_coord : scan read coordinate
//   x_pos, y_pos     : command cursor
//   cell_val         : cover state at the scan coordinate (00 if out of range)
//   opened_cell      : one-cycle pulse after a covered cell is opened
//   opened_count     : (BOARD_COVER_COUNT_EN only) saturating count of opens
// Build option: define BOARD_COVER_COUNT_EN to add opened_count.
module mine_board_cover
  import mine_board_cover_pkg::*;
#(
  parameter int X_SIZE       = DEFAULT_X_SIZE,
  parameter int Y_SIZE       = DEFAULT_Y_SIZE,
  parameter int X_COORD_BITS = DEFAULT_X_COORD_BITS,
  parameter int Y_COORD_BITS = DEFAULT_Y_COORD_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flag,
  input  logic                    open,
  input  logic [X_COORD_BITS-1:0] x_coord,
  input  logic [Y_COORD_BITS-1:0] y_coord,
  input  logic [X_COORD_BITS-1:0] x_pos,
  input  logic [Y_COORD_BITS-1:0] y_pos,
  output logic [1:0]              cell_val,
  output logic                    opened_cell
`ifdef BOARD_COVER_COUNT_EN
  ,
  output logic [X_COORD_BITS+Y_COORD_BITS:0] opened_count
`endif
);

  localparam int CELLS    = X_SIZE * Y_SIZE;
  localparam int IDX_BITS = X_COORD_BITS + Y_COORD_BITS;

  logic [1:0]       cell_state [CELLS];
  logic [CELLS-1:0] opened_vec;
  logic             cmd_flag;
  logic             cmd_open;

  // flag and open together cancel each other.
  assign cmd_flag = flag && !open;
  assign cmd_open = open && !flag;

  // An out-of-range cursor matches no cell, so the command is dropped.
  for (genvar gy = 0; gy < Y_SIZE; gy++) begin : g_row
    for (genvar gx = 0; gx < X_SIZE; gx++) begin : g_col
      logic sel;
      assign sel = (x_pos == X_COORD_BITS'(gx)) && (y_pos == Y_COORD_BITS'(gy));
      mine_board_cover_cell u_cell (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .flag   (cmd_flag),
        .open   (cmd_open),
        .state  (cell_state[gy*X_SIZE+gx]),
        .opened (opened_vec[gy*X_SIZE+gx])
      );
    end
  end

  // Scan read port.
  logic                rd_in_range;
  logic [IDX_BITS-1:0] rd_idx;

  assign rd_in_range = ({1'b0, x_coord} < (X_COORD_BITS+1)'(X_SIZE)) &&
                       ({1'b0, y_coord} < (Y_COORD_BITS+1)'(Y_SIZE));
  assign rd_idx      = IDX_BITS'(y_coord) * IDX_BITS'(X_SIZE) + IDX_BITS'(x_coord);
  assign cell_val    = rd_in_range ? cell_state[rd_idx] : COVER_HIDDEN;

  // At most one cell is selected, so the OR is exactly the accepted-open event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opened_cell <= 1'b0;
    end else begin
      opened_cell <= |opened_vec;
    end
  end

`ifdef BOARD_COVER_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opened_count <= '0;
    end else if ((|opened_vec) && (opened_count != (IDX_BITS+1)'(CELLS))) begin
      opened_count <= opened_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mine_board_cover.sv
module tb_mine_board_cover;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flag = 1'b0;
  logic       open = 1'b0;
  logic [3:0] x_coord = '0;
  logic [3:0] y_coord = '0;
  logic [3:0] x_pos = '0;
  logic [3:0] y_pos = '0;
  logic [1:0] cell_val;
  logic       opened_cell;
`ifdef BOARD_COVER_COUNT_EN
  logic [8:0] opened_count;
`endif

  always #5 clk = ~clk;

  mine_board_cover dut (
    .clk         (clk),
    .reset       (reset),
    .flag        (flag),
    .open        (open),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .cell_val    (cell_val),
    .opened_cell (opened_cell)
`ifdef BOARD_COVER_COUNT_EN
    ,
    .opened_count(opened_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // grid[y][x]: 0 covered, 1 opened, 2 flagged
  int grid [16][16];
  int exp_pulse;
  int exp_count;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          grid[y][x] = 0;
      exp_pulse = 0;
      exp_count = 0;
    end else begin
      exp_pulse = 0;
      if (open && !flag && grid[y_pos][x_pos] == 0) begin
        grid[y_pos][x_pos] = 1;
        exp_pulse = 1;
        if (exp_count < 256) exp_count++;
      end else if (flag && !open) begin
        if (grid[y_pos][x_pos] == 0)      grid[y_pos][x_pos] = 2;
        else if (grid[y_pos][x_pos] == 2) grid[y_pos][x_pos] = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cell_val_model", int'(cell_val), grid[y_coord][x_coord]);
      check("opened_cell_model", int'(opened_cell), exp_pulse);
`ifdef BOARD_COVER_COUNT_EN
      check("opened_count_model", int'(opened_count), exp_count);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Apply one command for exactly one edge; returns at edge+1.
  task automatic cmd(input bit f, input bit o, input int xp, input int yp);
    @(posedge clk);
    #1;
    flag = f; open = o; x_pos = 4'(xp); y_pos = 4'(yp);
    @(posedge clk);
    #1;
    flag = 1'b0; open = 1'b0;
  endtask

  task automatic peek(input int x, input int y, input int exp, input string name);
    x_coord = 4'(x); y_coord = 4'(y);
    #1;
    check(name, int'(cell_val), exp);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #3 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12 reset = 1'b0;
    cmp_en = 1'b1;

    // reset state: every cell covered, no pulse
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        peek(x, y, 0, "reset_scan");
    check("reset_pulse", int'(opened_cell), 0);

    // open (3,5)
    cmd(1'b0, 1'b1, 3, 5);
    check("open_pulse", int'(opened_cell), 1);
    peek(3, 5, 1, "open_3_5");
    peek(5, 3, 0, "untouched_5_3");
    @(posedge clk); #1;
    check("pulse_one_cycle", int'(opened_cell), 0);

    // flag / open-on-flag / unflag at (7,7)
    cmd(1'b1, 1'b0, 7, 7);
    peek(7, 7, 2, "flag_7_7");
    check("flag_no_pulse", int'(opened_cell), 0);
    cmd(1'b0, 1'b1, 7, 7);
    peek(7, 7, 2, "open_on_flag");
    check("open_on_flag_no_pulse", int'(opened_cell), 0);
    cmd(1'b1, 1'b0, 7, 7);
    peek(7, 7, 0, "unflag_7_7");

    // open (0,0), then flag and re-open do nothing
    cmd(1'b0, 1'b1, 0, 0);
    check("open_0_0_pulse", int'(opened_cell), 1);
    cmd(1'b1, 1'b0, 0, 0);
    peek(0, 0, 1, "flag_on_open");
    check("flag_on_open_no_pulse", int'(opened_cell), 0);
    cmd(1'b0, 1'b1, 0, 0);
    peek(0, 0, 1, "reopen");
    check("reopen_no_pulse", int'(opened_cell), 0);

    // both commands high
    cmd(1'b1, 1'b1, 2, 2);
    peek(2, 2, 0, "both_high");
    check("both_high_no_pulse", int'(opened_cell), 0);

    // held flag toggles every cycle: 3 edges -> flagged
    @(posedge clk); #1;
    flag = 1'b1; x_pos = 4'd9; y_pos = 4'd9;
    repeat (3) @(posedge clk);
    #1 flag = 1'b0;
    peek(9, 9, 2, "held_flag_3");

    // back-to-back opens of distinct cells
    @(posedge clk); #1;
    open = 1'b1; x_pos = 4'd1; y_pos = 4'd1;
    @(posedge clk); #1;
    check("b2b_pulse_1", int'(opened_cell), 1);
    x_pos = 4'd1; y_pos = 4'd2;
    @(posedge clk); #1;
    check("b2b_pulse_2", int'(opened_cell), 1);
    open = 1'b0;
    @(posedge clk); #1;
    check("b2b_pulse_end", int'(opened_cell), 0);

    // randomized traffic, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      flag    = ($urandom_range(0, 5) == 0);
      open    = ($urandom_range(0, 3) == 0);
      x_pos   = 4'($urandom_range(0, 15));
      y_pos   = 4'($urandom_range(0, 15));
      x_coord = 4'($urandom_range(0, 15));
      y_coord = 4'($urandom_range(0, 15));
      if (i == 1500) begin
        flag = 1'b0; open = 1'b0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(posedge clk); #1;
    flag = 1'b0; open = 1'b0;

`ifdef BOARD_COVER_COUNT_EN
    // open every cell so the counter reaches full scale and holds
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        cmd(1'b0, 1'b1, x, y);
    @(posedge clk); #1;
    check("count_full", int'(opened_count), 256);
`endif

    // asynchronous reset while a pulse is showing
    do_reset();
    cmd(1'b0, 1'b1, 15, 15);
    check("open_15_15_pulse", int'(opened_cell), 1);
    peek(15, 15, 1, "open_15_15");
    #1 reset = 1'b1;
    #1;
    check("async_reset_cell", int'(cell_val), 0);
    check("async_reset_pulse", int'(opened_cell), 0);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
